// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg
// Shared types and helpers for the line-buffer column feeder.
//   feeder_state_t : row-band sequencer states
//   KER_SIZE_DEF   : default kernel size
//   PAD_DEF        : default zero-padding width per side
//   pad_mask_left  : left-padding slot mask for presented column j
package line_buffer_pkg;

    localparam int KER_SIZE_DEF = 5;
    localparam int PAD_DEF      = (KER_SIZE_DEF - 1) / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } feeder_state_t;

    // Slot s still holds left padding after column j is written into slot j:
    // only the top PAD slots start as padding, and each real column written
    // at or above them replaces that padding.
    function automatic int unsigned pad_mask_left(input int unsigned j,
                                                  input int unsigned ker,
                                                  input int unsigned pad);
        int unsigned m;
        m = 0;
        for (int unsigned s = 0; s < ker; s++) begin
            if ((s >= ker - pad) && (s > j)) begin
                m = m | (32'd1 << s);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/line_buffer_col_feeder_skid.sv
// col_skid_buf
// One-entry skid register between the SRAM read port and the presented
// column register. Upstream cannot be stalled (SRAM data lands one cycle
// after the read strobe), so the feeder only issues a read when space is
// guaranteed; this buffer never sees a push while full and not draining.
//   clk         : clock
//   rstn        : synchronous active-low reset
//   in_valid_i  : SRAM data valid this cycle
//   in_data_i   : SRAM data
//   out_ready_i : consumer takes out_data_o this cycle
//   out_valid_o : data available (skid entry or pass-through)
//   out_data_o  : skid entry if held, otherwise incoming data
//   full_o      : skid entry occupied
module col_skid_buf #(
    parameter int DW = 40
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          out_ready_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic          full_o
);

    logic          full_q;
    logic [DW-1:0] data_q;

    assign out_valid_o = full_q | in_valid_i;
    assign out_data_o  = full_q ? data_q : in_data_i;
    assign full_o      = full_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (full_q) begin
            if (out_ready_i) begin
                full_q <= in_valid_i;
                data_q <= in_data_i;
            end
        end else if (in_valid_i && !out_ready_i) begin
            full_q <= 1'b1;
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/line_buffer_col_feeder.sv
// line_buffer_col_feeder
// Streams one KER_SIZE-tall pixel column per cycle from a row-band SRAM into
// a KxK window array, appending PAD zero columns at row end, with downstream
// backpressure and per-column slot/padding metadata.
//
// state  | meaning
// IDLE   | waiting for start; init_col_ptr parked at 0
// LOAD   | issuing the W column reads
// STREAM | all reads issued; draining real columns
// FLUSH  | presenting the PAD zero columns; done on last accept
//
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   start            : begin a row band (ignored while busy)
//   base_addr        : SRAM address of column 0 (sampled on start)
//   img_width        : columns in the row (sampled on start)
//   out_ready        : downstream accepts the presented column
//   rd_en, rd_addr   : SRAM read strobe / address
//   rd_data          : SRAM data, valid the cycle after rd_en
//   pixel_out        : presented column
//   col_valid        : pixel_out holds a new, unaccepted column
//   col_ptr          : array slot for the presented column
//   init_col_ptr     : array fill count
//   left_pad_mask    : array slots still holding left padding
//   right_pad_mask   : output-window columns that are right padding
//   win_valid        : array output register holds a new window
//   busy, done, err  : status
module line_buffer_col_feeder
    import line_buffer_pkg::*;
#(
    parameter int KER_SIZE = KER_SIZE_DEF,
    parameter int BITWIDTH = 8,
    parameter int AW       = 8,
    parameter int PAD      = (KER_SIZE - 1) / 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [AW-1:0]                base_addr,
    input  logic [AW-1:0]                img_width,
    input  logic                         out_ready,
    output logic                         rd_en,
    output logic [AW-1:0]                rd_addr,
    input  logic [BITWIDTH*KER_SIZE-1:0] rd_data,
    output logic [BITWIDTH*KER_SIZE-1:0] pixel_out,
    output logic                         col_valid,
    output logic [2:0]                   col_ptr,
    output logic [2:0]                   init_col_ptr,
    output logic [KER_SIZE-1:0]          left_pad_mask,
    output logic [KER_SIZE-1:0]          right_pad_mask,
    output logic                         win_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int DW = BITWIDTH * KER_SIZE;
    localparam int CW = AW + 2;
    localparam logic [2:0] PTR_LAST = 3'(KER_SIZE - 1);

    feeder_state_t state_q, state_d;

    logic [AW-1:0]       base_q, width_q;
    logic                prime_q;
    logic                rd_pend_q;
    logic [CW-1:0]       rd_cnt_q, pres_cnt_q, acc_cnt_q;
    logic [DW-1:0]       pix_q;
    logic                col_valid_q;
    logic [2:0]          col_ptr_q, nxt_ptr_q, init_q, nxt_init_q;
    logic [KER_SIZE-1:0] lmask_q, rmask_q;
    logic                win_valid_q, done_q, err_q;

    logic                sk_valid, sk_full;
    logic [DW-1:0]       sk_data;
    logic                acc, slot_free, start_ok, start_bad, rd_en_c;
    logic                present_real, present_flush, last_real_acc, last_acc;
    logic [CW-1:0]       width_c, flush_k;
    logic [1:0]          occ;
    logic [KER_SIZE-1:0] lmask_c, rmask_c;

    col_skid_buf #(.DW(DW)) u_skid (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (rd_pend_q),
        .in_data_i   (rd_data),
        .out_ready_i (slot_free),
        .out_valid_o (sk_valid),
        .out_data_o  (sk_data),
        .full_o      (sk_full)
    );

    assign width_c   = CW'(width_q);
    assign acc       = col_valid_q & out_ready;
    assign slot_free = ~col_valid_q | acc;
    assign start_ok  = start & (state_q == IDLE) & (img_width >= AW'(KER_SIZE));
    assign start_bad = start & (state_q == IDLE) & (img_width <  AW'(KER_SIZE));

    // Columns that will still be held after this edge (presented + skid +
    // data landing now). A new read lands two edges later into the 2-entry
    // storage (output register + skid), so at most one may remain.
    assign occ     = 2'(col_valid_q) + 2'(sk_full) + 2'(rd_pend_q) - 2'(acc);
    assign rd_en_c = (state_q == LOAD) & ~prime_q & (rd_cnt_q < width_c) & (occ <= 2'd1);

    assign present_real  = slot_free & sk_valid;
    assign present_flush = slot_free & ~sk_valid
                         & ((state_q == STREAM) | (state_q == FLUSH))
                         & (pres_cnt_q >= width_c)
                         & (pres_cnt_q < width_c + CW'(PAD));

    assign last_real_acc = acc & (acc_cnt_q == width_c - CW'(1));
    assign last_acc      = acc & (acc_cnt_q == width_c + CW'(PAD) - CW'(1));

    // Flush index 1..PAD of the column being accepted (meaningful only when
    // the accepted column lies past the real ones).
    assign flush_k = acc_cnt_q - width_c + CW'(1);
    assign lmask_c = KER_SIZE'(pad_mask_left(32'(pres_cnt_q), KER_SIZE, PAD));

    always_comb begin
        rmask_c = '0;
        if (acc_cnt_q >= width_c) begin
            for (int s = 0; s < KER_SIZE; s++) begin
                rmask_c[s] = (CW'(s) + flush_k >= CW'(KER_SIZE));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (rd_en_c && (rd_cnt_q + CW'(1) == width_c)) state_d = STREAM;
            STREAM:  if (last_real_acc) state_d = FLUSH;
            FLUSH:   if (last_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            base_q      <= '0;
            width_q     <= '0;
            prime_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_cnt_q    <= '0;
            pres_cnt_q  <= '0;
            acc_cnt_q   <= '0;
            pix_q       <= '0;
            col_valid_q <= 1'b0;
            col_ptr_q   <= '0;
            nxt_ptr_q   <= '0;
            init_q      <= '0;
            nxt_init_q  <= '0;
            lmask_q     <= '0;
            rmask_q     <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q       <= start_bad;
            done_q      <= 1'b0;
            win_valid_q <= acc & (init_q == PTR_LAST);
            rd_pend_q   <= rd_en_c;
            // The read issue decision waits one cycle after start so the
            // first strobe lands in the cycle after start is sampled.
            prime_q     <= 1'b0;

            if (start_ok) begin
                base_q     <= base_addr;
                width_q    <= img_width;
                prime_q    <= 1'b1;
                rd_cnt_q   <= '0;
                pres_cnt_q <= '0;
                acc_cnt_q  <= '0;
                nxt_ptr_q  <= '0;
                nxt_init_q <= 3'(PAD);
                rmask_q    <= '0;
            end

            if (rd_en_c) begin
                rd_cnt_q <= rd_cnt_q + CW'(1);
            end

            if (acc) begin
                acc_cnt_q   <= acc_cnt_q + CW'(1);
                rmask_q     <= rmask_c;
                col_valid_q <= 1'b0;
            end

            if (present_real || present_flush) begin
                pix_q       <= present_real ? sk_data : '0;
                lmask_q     <= present_real ? lmask_c : '0;
                col_valid_q <= 1'b1;
                col_ptr_q   <= nxt_ptr_q;
                nxt_ptr_q   <= (nxt_ptr_q == PTR_LAST) ? 3'd0 : nxt_ptr_q + 3'd1;
                init_q      <= nxt_init_q;
                nxt_init_q  <= (nxt_init_q == PTR_LAST) ? PTR_LAST : nxt_init_q + 3'd1;
                pres_cnt_q  <= pres_cnt_q + CW'(1);
            end

            // Parking the fill count at 0 freezes the array output between rows.
            if ((state_q == FLUSH) && last_acc) begin
                done_q <= 1'b1;
                init_q <= '0;
            end
        end
    end

    assign rd_en          = rd_en_c;
    assign rd_addr        = base_q + rd_cnt_q[AW-1:0];
    assign pixel_out      = pix_q;
    assign col_valid      = col_valid_q;
    assign col_ptr        = col_ptr_q;
    assign init_col_ptr   = init_q;
    assign left_pad_mask  = lmask_q;
    assign right_pad_mask = rmask_q;
    assign win_valid      = win_valid_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_line_buffer_col_feeder.sv
// Self-checking bench for line_buffer_col_feeder (K=5, PAD=2, AW=8).
module tb_line_buffer_col_feeder;

    localparam int K   = 5;
    localparam int BW  = 8;
    localparam int AW  = 8;
    localparam int PAD = 2;
    localparam int DW  = K * BW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] img_width;
    logic          out_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] pixel_out;
    logic          col_valid;
    logic [2:0]    col_ptr;
    logic [2:0]    init_col_ptr;
    logic [K-1:0]  left_pad_mask;
    logic [K-1:0]  right_pad_mask;
    logic          win_valid;
    logic          busy;
    logic          done;
    logic          err;

    line_buffer_col_feeder #(.KER_SIZE(K), .BITWIDTH(BW), .AW(AW), .PAD(PAD)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .base_addr      (base_addr),
        .img_width      (img_width),
        .out_ready      (out_ready),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .pixel_out      (pixel_out),
        .col_valid      (col_valid),
        .col_ptr        (col_ptr),
        .init_col_ptr   (init_col_ptr),
        .left_pad_mask  (left_pad_mask),
        .right_pad_mask (right_pad_mask),
        .win_valid      (win_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] e_pix  [300];
    logic [2:0]    e_ptr  [300];
    logic [2:0]    e_init [300];
    logic [K-1:0]  e_lm   [300];
    logic [K-1:0]  e_rm   [300];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {rd_en, rd_addr, col_valid, col_ptr, init_col_ptr,
                              left_pad_mask, right_pad_mask, win_valid, busy, done, err}, 64'd0);
        check({tag, "_pix"}, pixel_out, 64'd0);
    endtask

    // Reference sequence of presented columns, built straight from the
    // column rules: data from base+j mod 256, slot j mod K, fill count
    // PAD+j saturating at K-1, padding masks from slot/column positions.
    task automatic build_model(input logic [AW-1:0] base, input int w);
        for (int j = 0; j < w + PAD; j++) begin
            int fill;
            fill      = (PAD + j > K - 1) ? K - 1 : PAD + j;
            e_ptr[j]  = 3'(j % K);
            e_init[j] = 3'(fill);
            e_lm[j]   = '0;
            e_rm[j]   = '0;
            if (j < w) begin
                e_pix[j] = mem[AW'(base + j)];
                for (int s = 0; s < K; s++) e_lm[j][s] = (s >= K - PAD) && (s > j);
            end else begin
                e_pix[j] = '0;
                for (int s = 0; s < K; s++) e_rm[j][s] = (s >= K - (j - w + 1));
            end
        end
    endtask

    task automatic run_row(input logic [AW-1:0] base, input int w, input int mode,
                           input int abort_cyc, input bit inject);
        int ncol, acc_n, rd_n, win_n, prev_acc, done_cyc, budget;
        bit prev_stall, done_seen, exp_done, exp_win;
        logic [DW-1:0] prev_pix;
        logic [2:0] prev_ptr;

        ncol = w + PAD; acc_n = 0; rd_n = 0; win_n = 0; prev_acc = -1;
        done_cyc = -1; budget = 30 * w + 60;
        prev_stall = 0; done_seen = 0; prev_pix = '0; prev_ptr = '0;
        build_model(base, w);

        base_addr = base;
        img_width = AW'(w);
        start     = 1'b1;
        out_ready = 1'b1;

        for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (inject && cyc == 4) begin
                start     = 1'b1;
                base_addr = 8'h80;
                img_width = 8'd6;
            end
            out_ready = ready_for(mode, cyc);
            rstn      = !(abort_cyc >= 0 && cyc == abort_cyc);
            #1;

            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check_all_zero("abort_reset");
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    #2;
                    check("abort_no_done", {done, busy, rd_en}, 64'd0);
                end
                return;
            end

            check("err_quiet", err, 1'b0);
            if (rd_en) begin
                check("rd_addr", rd_addr, AW'(base + rd_n));
                check("rd_count_ok", rd_n < w, 1'b1);
                rd_n++;
            end

            exp_win = (prev_acc >= 0) && (e_init[prev_acc] == 3'(K - 1));
            check("win_valid", win_valid, exp_win);
            if (win_valid) win_n++;
            if (prev_acc >= 0) check("right_pad_mask", right_pad_mask, e_rm[prev_acc]);

            exp_done = (prev_acc == ncol - 1);
            check("done", done, exp_done);
            check("busy", busy, !exp_done);
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end

            if (prev_stall) begin
                check("stall_valid", col_valid, 1'b1);
                check("stall_pix", pixel_out, prev_pix);
                check("stall_ptr", col_ptr, prev_ptr);
            end

            if (mode == 0) begin
                check("rd_en_timing", rd_en, (cyc >= 1) && (cyc <= w));
                check("col_valid_timing", col_valid, (cyc >= 3) && (cyc <= 2 + ncol));
            end

            prev_acc   = -1;
            prev_stall = 0;
            if (col_valid) begin
                check("col_in_range", acc_n < ncol, 1'b1);
                if (acc_n < ncol) begin
                    check("pixel_out", pixel_out, e_pix[acc_n]);
                    check("col_ptr", col_ptr, e_ptr[acc_n]);
                    check("init_col_ptr", init_col_ptr, e_init[acc_n]);
                    check("left_pad_mask", left_pad_mask, e_lm[acc_n]);
                end
                if (out_ready) begin
                    prev_acc = acc_n;
                    acc_n++;
                end else begin
                    prev_stall = 1;
                    prev_pix   = pixel_out;
                    prev_ptr   = col_ptr;
                end
            end
        end

        check("row_done_seen", done_seen, 1'b1);
        check("cols_accepted", acc_n, ncol);
        check("windows", win_n, w);
        check("reads", rd_n, w);
        if (mode == 0) check("done_cycle", done_cyc, 3 + w + PAD);

        @(posedge clk);
        #2;
        check("idle_state", {done, busy, col_valid, init_col_ptr, win_valid}, 64'd0);
        check("idle_rpad_hold", right_pad_mask, e_rm[ncol - 1]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            mem[i] = r[DW-1:0];
        end

        rstn = 1'b0; start = 1'b0; base_addr = '0; img_width = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Full rate, W=8 at 0x10, with a second start mid-row that must be ignored.
        run_row(8'h10, 8, 0, -1, 1'b1);
        // Backpressure pattern 1,0,0,1.
        run_row(8'($urandom_range(0, 255)), 8, 1, -1, 1'b0);
        // Address wrap.
        run_row(8'hFE, 5, 0, -1, 1'b0);

        // Too-narrow row is rejected.
        base_addr = 8'h40; img_width = 8'd3; start = 1'b1;
        @(posedge clk);
        #1; start = 1'b0;
        #1;
        check("err_pulse", err, 1'b1);
        check("err_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("err_after", {err, busy, rd_en}, 64'd0);
        end

        // Reset in cycle 7 of a row, then a clean row.
        run_row(8'h20, 8, 0, 7, 1'b0);
        run_row(8'($urandom_range(0, 255)), 8, 2, -1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            run_row(8'($urandom_range(0, 255)), $urandom_range(K, 20), 2, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
